tff_updown_counter: RTL
=======================

Name: tff_updown_counter

Overview:
- Synchronous modulo-N up/down counter built from toggle-flip-flop cells. Each cell is driven by a toggle-enable signal computed from the current count.
- Sits directly downstream of the single T flip-flop stage in module 3: it chains that stage into a multi-bit counter with load and terminal-count outputs.
- Feeds the display and divider labs that follow.

Parameters:
- WIDTH, 4, count register width in bits (≥1).
- MODULUS, 10, counting range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count; each bit is a T flip-flop output.
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0: q=0 and wrap=0 immediately, independent of clk.
- Release of rst_n takes effect on the next rising clk edge.
- Storage: every bit of q is a T flip-flop.
  - t[i] = q[i] XOR next[i], where next is the target value defined below.
  - No D-style bypass of the cells.
- Priority at each rising edge: load, then en, then hold.
  - load=1: next = d when d < MODULUS, otherwise next = MODULUS-1 (clamp). load ignores en and up.
  - load=0, en=1, up=1: next = 0 if q == MODULUS-1, else q+1.
  - load=0, en=1, up=0: next = MODULUS-1 if q == 0, else q-1.
  - load=0, en=0: next = q (all t=0).
- Latency: q reflects the update one clock after the request is sampled.
- tc (combinational):
  - tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
  - High in exactly the cycle whose edge will wrap.
- wrap: registered copy of tc. It is 1 for exactly one cycle after each wrap edge and 0 otherwise.
- Out-of-range state: if q ≥ MODULUS, which is only reachable when MODULUS < 2**WIDTH, next = 0 on any enabled count in either direction. tc=0 in such a state.
- Power-of-two MODULUS: counting behaves as natural binary wrap. The t[i] equations reduce to the classic ripple-carry AND chain; the implementation may use either form.
- Direction change: up may change on any cycle; only the value sampled at the edge matters. There is no hysteresis or extra latency.
- Reset mid-count: abandons the count immediately; q=0. A wrap pulse in progress is cleared.
- Simultaneous load and en: load wins, and no wrap pulse is generated even if q was at terminal.

Decomposition:
- No shared package is needed. WIDTH and MODULUS are local parameters of the module.
- One sub-module, tff_cell, with ports clk, rst_n, t, q.
  - Async active-low reset to 0; toggles on a rising clk edge when t=1.
  - Instantiated WIDTH times via generate.
- Next-value and toggle logic live in the parent as combinational always blocks.
- wrap is a plain register in the parent.

Test Plan:
- Reset: hold rst_n=0 with en=1 for 3 clocks, then deassert → q=0 throughout and wrap=0. Assert rst_n=0 mid-count at q=7 between clock edges → q=0 immediately.
- Up count, defaults (WIDTH=4, MODULUS=10): en=1, up=1 for 12 clocks from 0.
  - q sequence is 1..9, 0, 1, 2.
  - tc=1 only while q=9; wrap=1 in the single cycle where q=0 after the wrap.
- Down count: load d=2, then en=1, up=0 for 4 clocks → q = 2, 1, 0, 9, 8. tc=1 while q=0; wrap pulses once.
- Load priority and clamp:
  - load=1, en=1, d=5 → q=5.
  - load=1, d=13 → q=9.
  - With q=9, up=1, en=1, load=1, d=3 → q=3, tc=0, no wrap pulse.
- Hold and direction flip: en=0 for 5 clocks at q=4 → q stays 4, all t=0. Then alternate up=1/0 each clock with en=1 → q oscillates 5, 4, 5, 4.
- Power-of-two config (WIDTH=3, MODULUS=8): en=1, up=1 for 9 clocks → q = 1..7, 0, 1; wrap pulses once after 7→0.

Source files
------------

// File: rtl/tff_cell.sv
// Single toggle flip-flop: flips its state on a rising clk edge when t=1.
// Asynchronous active-low reset clears the stored bit to 0.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter whose state lives entirely in T flip-flop cells.
// The parent computes the target value and drives each cell's toggle as q ^ target.
module tff_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // One extra bit so MODULUS == 2**WIDTH is still representable in compares.
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] t_d;
    logic             in_range;
    logic             wrap_d;
    logic             wrap_q;

    always_comb begin
        in_range = ({1'b0, q} < MOD_EXT);
        next_d   = q;
        if (load) begin
            next_d = ({1'b0, d} < MOD_EXT) ? d : MAX_Q;
        end else if (en) begin
            // An out-of-range state recovers to 0 regardless of direction.
            if (!in_range) begin
                next_d = '0;
            end else if (up) begin
                next_d = (q == MAX_Q) ? '0 : q + WIDTH'(1);
            end else begin
                next_d = (q == '0) ? MAX_Q : q - WIDTH'(1);
            end
        end
        t_d    = q ^ next_d;
        tc     = en & ~load & ((up & (q == MAX_Q)) | (~up & (q == '0)));
        wrap_d = tc;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_d[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule
